hwpf_req_arbiter: RTL and testbench
===================================

Name: hwpf_req_arbiter

Overview:
- Shares the single dcache request port between demand CPU requests and the next-line prefetcher FIFO (hwpf_fifo).
- Sequences FIFO reads, holds one prefetch in a skid register, and throttles prefetch issue with a minimum-gap counter and an outstanding-prefetch credit limit.
- Sits between the CPU LSU request path, hwpf_fifo and the dcache request interface.
- CPU demand requests always have priority.

Parameters:
- MAX_OUTSTANDING, 4, maximum prefetches issued to the dcache and not yet responded to.
- MIN_GAP, 2, minimum idle cycles between two prefetch grants (0 = back-to-back allowed).
- cpu_addr_t, req_cpu_dcache_t, request structure type shared with hwpf_fifo and the dcache.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- flush_i  in  1  pipeline flush; drops the held prefetch
- enable_i  in  1  prefetcher enable; 0 blocks new FIFO reads
- cpu_req_valid_i  in  1  demand request valid
- cpu_req_i  in  cpu_addr_t  demand request
- cpu_req_ready_o  out  1  demand request accepted this cycle
- pf_read_o  out  1  one-cycle read pulse to hwpf_fifo read_i
- pf_valid_i  in  1  FIFO output valid (arbiter_req_valid_o)
- pf_req_i  in  cpu_addr_t  FIFO output request (arbiter_req_o)
- pf_resp_i  in  1  dcache returned a response for a prefetch (one credit back)
- dcache_ready_i  in  1  dcache accepts a request this cycle
- dcache_req_valid_o  out  1  request valid to dcache
- dcache_req_o  out  cpu_addr_t  request to dcache
- dcache_req_is_pf_o  out  1  current dcache request is a prefetch
- pf_outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  outstanding prefetch count

Behaviour:
- Reset: FSM=IDLE; hold register cleared; gap counter=0; credit counter=0. All outputs 0, except cpu_req_ready_o, which follows dcache_ready_i.
- Demand path is combinational:
  - dcache_req_valid_o = cpu_req_valid_i | (state==HOLD).
  - dcache_req_o = cpu_req_i when cpu_req_valid_i, else the held prefetch.
  - cpu_req_ready_o = dcache_ready_i.
  - dcache_req_is_pf_o = ~cpu_req_valid_i & (state==HOLD).
- Prefetch grant = state==HOLD & ~cpu_req_valid_i & dcache_ready_i.
- FSM states:
  - IDLE: if enable_i & ~flush_i & gap==0 & credits<MAX_OUTSTANDING, assert pf_read_o for one cycle and go to FETCH.
  - FETCH (exactly 1 cycle, FIFO output latency): if pf_valid_i & ~flush_i, capture pf_req_i into hold and go to HOLD; else go to IDLE (FIFO empty or flushed).
  - HOLD: wait for grant. On grant: credits+1, gap loaded with MIN_GAP, go to IDLE. flush_i drops the hold, go to IDLE, no credit taken.
- Gap counter: decrements by 1 each cycle while nonzero. Saturates at 0.
- Credit counter:
  - +1 on grant, -1 on pf_resp_i. Simultaneous grant and pf_resp_i leaves it unchanged.
  - pf_resp_i at 0 is ignored (no underflow).
  - Never exceeds MAX_OUTSTANDING; grants are impossible at the limit because IDLE does not read.
  - flush_i does not clear credits; in-flight prefetches still return responses.
- enable_i deassert: no new reads from IDLE. A prefetch already in FETCH/HOLD completes normally.
- pf_read_o is never asserted outside IDLE, so at most one prefetch is in the arbiter at a time.
- CPU requests stall a held prefetch indefinitely (no starvation guard; the prefetch is speculative).
- Async reset mid-operation returns everything to reset values immediately. The held request is lost.

Test Plan:
- Reset, enable_i=1, FIFO supplies addr 0x1040 in FETCH, no CPU traffic, dcache_ready_i=1 -> pf_read_o at cycle 1, grant at cycle 3 with dcache_req_is_pf_o=1, pf_outstanding_o=1, next pf_read_o no earlier than cycle 3+MIN_GAP+1.
- Prefetch in HOLD while cpu_req_valid_i=1 for 5 cycles -> CPU request 0x2000 forwarded each cycle with is_pf=0; prefetch granted in the first cycle CPU is idle.
- Issue 4 prefetches with no pf_resp_i (MAX_OUTSTANDING=4) -> pf_outstanding_o=4 and pf_read_o stays 0. One pf_resp_i pulse -> count=3, next read within MIN_GAP+1 cycles.
- flush_i while in HOLD -> hold dropped, no dcache prefetch issued, credits unchanged, FSM back to IDLE.
- FETCH with pf_valid_i=0 (empty FIFO) -> return to IDLE, no credit change, retry read next eligible cycle.
- Grant and pf_resp_i in the same cycle at count=2 -> count stays 2. pf_resp_i at count 0 -> count stays 0.

Source files
------------

// File: rtl/hwpf_req_arbiter.sv
// Arbitrates the single dcache request port between demand CPU requests and the
// next-line prefetch FIFO, throttling prefetches by a minimum gap and a credit limit.
module hwpf_req_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned MIN_GAP         = 2,
  parameter type         cpu_addr_t      = logic [31:0]
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   flush_i,
  input  logic                                   enable_i,
  input  logic                                   cpu_req_valid_i,
  input  cpu_addr_t                              cpu_req_i,
  output logic                                   cpu_req_ready_o,
  output logic                                   pf_read_o,
  input  logic                                   pf_valid_i,
  input  cpu_addr_t                              pf_req_i,
  input  logic                                   pf_resp_i,
  input  logic                                   dcache_ready_i,
  output logic                                   dcache_req_valid_o,
  output cpu_addr_t                              dcache_req_o,
  output logic                                   dcache_req_is_pf_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   pf_outstanding_o
);

  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned GapW = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;

  localparam logic [CntW-1:0] MaxCred = CntW'(MAX_OUTSTANDING);
  localparam logic [CntW-1:0] CredOne = CntW'(1);
  localparam logic [GapW-1:0] GapLoad = GapW'(MIN_GAP);
  localparam logic [GapW-1:0] GapOne  = GapW'(1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } state_e;

  state_e          state_q, state_d;
  cpu_addr_t       hold_q, hold_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [CntW-1:0] cred_q, cred_d;
  logic            grant;
  logic            can_read;

  always_comb begin
    can_read = (state_q == IDLE) & enable_i & ~flush_i & (gap_q == '0) & (cred_q < MaxCred);
    grant    = (state_q == HOLD) & ~cpu_req_valid_i & dcache_ready_i;

    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE:  if (can_read) state_d = FETCH;
      FETCH: begin
        if (pf_valid_i && !flush_i) begin
          hold_d  = pf_req_i;
          state_d = HOLD;
        end else begin
          state_d = IDLE;
        end
      end
      // A grant coinciding with flush has already been accepted by the dcache,
      // so it still consumes a credit; flush alone just discards the hold.
      HOLD:    if (grant || flush_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    gap_d = gap_q;
    if (grant) begin
      gap_d = GapLoad;
    end else if (gap_q != '0) begin
      gap_d = gap_q - GapOne;
    end

    cred_d = cred_q;
    case ({grant, pf_resp_i})
      2'b10:   cred_d = cred_q + CredOne;
      2'b01:   if (cred_q != '0) cred_d = cred_q - CredOne;
      default: cred_d = cred_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      hold_q  <= '0;
      gap_q   <= '0;
      cred_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      cred_q  <= cred_d;
    end
  end

  assign pf_read_o          = can_read;
  assign cpu_req_ready_o    = dcache_ready_i;
  assign dcache_req_valid_o = cpu_req_valid_i | (state_q == HOLD);
  assign dcache_req_o       = cpu_req_valid_i ? cpu_req_i : hold_q;
  assign dcache_req_is_pf_o = ~cpu_req_valid_i & (state_q == HOLD);
  assign pf_outstanding_o   = cred_q;

endmodule

// File: tb/tb_hwpf_req_arbiter.sv
// Directed bench for hwpf_req_arbiter: models the prefetch FIFO and scoreboards
// every request the dcache accepts against the addresses the bench drove.
module tb_hwpf_req_arbiter;

  localparam int unsigned MAXO = 4;
  localparam int unsigned GAP  = 2;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, en, cpu_v, cpu_rdy, pf_rd, pf_v, pf_resp, dc_rdy, dc_v, dc_pf;
  logic [31:0] cpu_req, pf_req, dc_req;
  logic [2:0]  outst;

  hwpf_req_arbiter #(
    .MAX_OUTSTANDING(MAXO),
    .MIN_GAP        (GAP),
    .cpu_addr_t     (logic [31:0])
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .flush_i           (flush),
    .enable_i          (en),
    .cpu_req_valid_i   (cpu_v),
    .cpu_req_i         (cpu_req),
    .cpu_req_ready_o   (cpu_rdy),
    .pf_read_o         (pf_rd),
    .pf_valid_i        (pf_v),
    .pf_req_i          (pf_req),
    .pf_resp_i         (pf_resp),
    .dcache_ready_i    (dc_rdy),
    .dcache_req_valid_o(dc_v),
    .dcache_req_o      (dc_req),
    .dcache_req_is_pf_o(dc_pf),
    .pf_outstanding_o  (outst)
  );

  int unsigned tests = 0, fails = 0;
  int unsigned cyc = 0, reads = 0, grants = 0, last_read_cyc = 0, grant_cyc = 0;
  logic        rd_s;
  logic [31:0] fifo_q[$];
  logic [31:0] cpu_exp[$];
  logic [31:0] pf_exp[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, then advance and drive the FIFO model after posedge.
  task automatic cycle();
    @(negedge clk);
    rd_s = pf_rd;
    if (pf_rd) begin
      reads++;
      last_read_cyc = cyc;
    end
    if (dc_v && dc_rdy) begin
      if (cpu_v) begin
        chk("cpu_pending", 32'(cpu_exp.size() != 0), 32'd1);
        if (cpu_exp.size() != 0) chk("cpu_addr", dc_req, cpu_exp.pop_front());
        chk("cpu_is_pf", 32'(dc_pf), 32'd0);
        chk("cpu_ready", 32'(cpu_rdy), 32'd1);
      end else begin
        chk("pf_pending", 32'(pf_exp.size() != 0), 32'd1);
        if (pf_exp.size() != 0) chk("pf_addr", dc_req, pf_exp.pop_front());
        chk("pf_is_pf", 32'(dc_pf), 32'd1);
        grants++;
        grant_cyc = cyc;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    pf_resp = 1'b0;
    pf_v    = rd_s && (fifo_q.size() != 0);
    if (pf_v) begin
      pf_req = fifo_q.pop_front();
      pf_exp.push_back(pf_req);
    end else begin
      pf_req = '0;
    end
  endtask

  task automatic cpu_cycles(input logic [31:0] a, input int unsigned n);
    cpu_v   = 1'b1;
    cpu_req = a;
    for (int unsigned i = 0; i < n; i++) begin
      if (dc_rdy) cpu_exp.push_back(a);
      cycle();
    end
    cpu_v   = 1'b0;
    cpu_req = '0;
  endtask

  task automatic wait_reads(input int unsigned n, input int unsigned bound, input string tag);
    int unsigned k = 0;
    while (reads < n && k < bound) begin
      cycle();
      k++;
    end
    chk({tag, "_timeout"}, 32'(reads >= n), 32'd1);
  endtask

  task automatic wait_grants(input int unsigned n, input int unsigned bound, input string tag);
    int unsigned k = 0;
    while (grants < n && k < bound) begin
      cycle();
      k++;
    end
    chk({tag, "_timeout"}, 32'(grants >= n), 32'd1);
  endtask

  initial begin
    int unsigned g0, r0, c0;
    rst_n = 1'b1; flush = 1'b0; en = 1'b0; cpu_v = 1'b0; cpu_req = '0;
    pf_v = 1'b0; pf_req = '0; pf_resp = 1'b0; dc_rdy = 1'b1; rd_s = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dc_valid", 32'(dc_v), 32'd0);
    chk("rst_pf_read", 32'(pf_rd), 32'd0);
    chk("rst_is_pf", 32'(dc_pf), 32'd0);
    chk("rst_outst", 32'(outst), 32'd0);
    chk("rst_dc_req", dc_req, 32'd0);
    chk("rst_cpu_ready_hi", 32'(cpu_rdy), 32'd1);
    dc_rdy = 1'b0;
    #1 chk("rst_cpu_ready_lo", 32'(cpu_rdy), 32'd0);
    dc_rdy = 1'b1;

    // Basic prefetch: read at cycle 1, grant at cycle 3
    @(posedge clk);
    #1;
    rst_n = 1'b1; en = 1'b1; cyc = 1;
    fifo_q.push_back(32'h1040);
    cycle();
    chk("first_read_cyc", last_read_cyc, 32'd1);
    cycle();
    cycle();
    chk("first_grant_cyc", grant_cyc, 32'd3);
    chk("outst_after_first", 32'(outst), 32'd1);
    wait_reads(2, 20, "gap");
    chk("gap_next_read_cyc", last_read_cyc, 32'(3 + GAP + 1));

    // Empty FIFO in FETCH: back to IDLE, retry on the next eligible cycle
    wait_reads(3, 10, "empty_retry");
    chk("empty_retry_cyc", last_read_cyc, 32'(3 + GAP + 3));
    chk("empty_outst", 32'(outst), 32'd1);
    en = 1'b0;

    // CPU traffic stalls a held prefetch; enable drop does not abort FETCH
    repeat (3) cycle();
    fifo_q.push_back(32'h3000);
    en = 1'b1;
    wait_reads(4, 10, "stall_read");
    en = 1'b0;
    g0 = grants;
    cpu_cycles(32'h2000, 6);
    chk("pf_stalled", grants, g0);
    c0 = cyc;
    cycle();
    chk("pf_after_cpu_cyc", grant_cyc, c0);
    chk("pf_after_cpu_cnt", grants, g0 + 1);
    chk("outst_two", 32'(outst), 32'd2);

    // Credit limit
    fifo_q.push_back(32'h4000);
    fifo_q.push_back(32'h4040);
    en = 1'b1;
    wait_grants(4, 40, "fill_credits");
    chk("outst_full", 32'(outst), 32'(MAXO));
    r0 = reads;
    repeat (10) cycle();
    chk("no_read_at_limit", reads, r0);
    fifo_q.push_back(32'h5000);
    pf_resp = 1'b1;
    c0 = cyc;
    cycle();
    chk("outst_after_resp", 32'(outst), 32'd3);
    wait_reads(r0 + 1, GAP + 1, "resp_read");
    chk("resp_read_cyc", last_read_cyc, c0 + 1);

    // Flush while holding: nothing issued, credits kept, back in IDLE
    dc_rdy = 1'b0; en = 1'b0;
    cycle();
    chk("hold_valid", 32'(dc_v), 32'd1);
    chk("hold_is_pf", 32'(dc_pf), 32'd1);
    chk("hold_addr", dc_req, 32'h5000);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    pf_exp.delete();
    g0 = grants;
    dc_rdy = 1'b1;
    repeat (3) cycle();
    chk("flush_no_grant", grants, g0);
    chk("flush_outst", 32'(outst), 32'd3);
    chk("flush_dc_valid", 32'(dc_v), 32'd0);
    r0 = reads;
    en = 1'b1;
    cycle();
    chk("flush_idle_read", reads, r0 + 1);
    en = 1'b0;

    // Simultaneous grant and response at count 2
    pf_resp = 1'b1;
    cycle();
    chk("outst_dec_two", 32'(outst), 32'd2);
    fifo_q.push_back(32'h6000);
    dc_rdy = 1'b0; en = 1'b1;
    wait_reads(reads + 1, 10, "simul_read");
    en = 1'b0;
    cycle();
    dc_rdy = 1'b1; pf_resp = 1'b1;
    g0 = grants;
    cycle();
    chk("simul_grant", grants, g0 + 1);
    chk("simul_outst", 32'(outst), 32'd2);

    // Asynchronous reset mid-hold
    fifo_q.push_back(32'h7000);
    dc_rdy = 1'b0; en = 1'b1;
    wait_reads(reads + 1, 10, "areset_read");
    en = 1'b0;
    cycle();
    chk("areset_pre_valid", 32'(dc_v), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_dc_valid", 32'(dc_v), 32'd0);
    chk("areset_dc_req", dc_req, 32'd0);
    chk("areset_is_pf", 32'(dc_pf), 32'd0);
    chk("areset_outst", 32'(outst), 32'd0);
    pf_exp.delete();
    cycle();
    rst_n = 1'b1; dc_rdy = 1'b1;

    // Response at zero credits is ignored
    pf_resp = 1'b1;
    cycle();
    chk("resp_at_zero", 32'(outst), 32'd0);

    chk("cpu_queue_drained", 32'(cpu_exp.size()), 32'd0);
    chk("pf_queue_drained", 32'(pf_exp.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
